// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge with a PREADY timeout that reports AHB ERROR.
// Latency: each accepted transfer runs SETUP then ACCESS, so at least one AHB wait state.
// Backpressure: HREADYOUT stays low through SETUP and ACCESS until PREADY, or until the timeout.
module ahb_apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic              PREADY,
    input  logic [31:0]       PRDATA
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             launch;
    logic             timed_out;

    assign accept    = HSEL & HREADY & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
    // A new transfer can start only where the bridge is itself signalling ready.
    assign launch    = accept & HREADYOUT;
    assign timed_out = TO_EN & (cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            cnt     <= '0;
        end else if (launch) begin
            state   <= ST_SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= HADDR;
            PWRITE  <= HWRITE;
        end else begin
            case (state)
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state   <= ST_IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timed_out) begin
                            state   <= ST_ERR1;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                        end
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        HREADYOUT = 1'b0;
        case (state)
            ST_IDLE:   HREADYOUT = 1'b1;
            ST_ERR2:   HREADYOUT = 1'b1;
            ST_ACCESS: HREADYOUT = PREADY;
            default:   HREADYOUT = 1'b0;
        endcase
    end

    assign HRESP  = (state == ST_ERR1) | (state == ST_ERR2);
    assign HRDATA = ((state == ST_ACCESS) && PREADY && !PWRITE) ? PRDATA : 32'h0;
    // HWDATA is held by the master while HREADYOUT is low, so it can feed APB directly.
    assign PWDATA = HWDATA;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
module tb_ahb_apb_bridge;
    localparam int TO = 4;
    localparam int NR = 150;

    logic        PCLK, PRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic        PSEL, PENABLE, PWRITE, PREADY, hready_ext;
    logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
    logic [1:0]  HTRANS;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] slv_mem [64];
    logic [31:0] ref_mem [64];
    int          slv_wait = 0;
    int          acc_cnt = 0;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic        acc;
        logic [31:0] exp_paddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        seq;
        logic [31:0] wdata;
        int          w;
        int          gap;
    } xf_t;

    assign HREADY = HREADYOUT & hready_ext;

    ahb_apb_bridge #(.ADDR_W(32), .TIMEOUT(TO), .CNT_W(3)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // APB peripheral: PREADY low for slv_wait ACCESS cycles, then high; writes land at the clock edge.
    initial begin
        PREADY = 1'b0;
        PRDATA = 32'h0;
        forever begin
            @(posedge PCLK);
            if (PRESETn && PSEL && PENABLE && PREADY && PWRITE) slv_mem[PADDR[7:2]] = PWDATA;
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                PREADY = (acc_cnt >= slv_wait);
                if (acc_cnt < slv_wait) acc_cnt++;
            end else begin
                PREADY  = 1'b0;
                acc_cnt = 0;
            end
            PRDATA = (PSEL && !PWRITE) ? slv_mem[PADDR[7:2]] : $urandom;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic bus(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
        HSEL   = sel;
        HTRANS = tr;
        HWRITE = wr;
        HADDR  = a;
    endtask

    initial begin
        vec_t        vt [7];
        xf_t         xq [NR];
        int          n, n_psel, ap, dp, dp_cyc, gap_left, cyc, nxt, idx, mm;
        bit          presenting, exp_err;
        logic [31:0] v;

        vt[0] = '{1'b1, 2'b10, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10};
        vt[1] = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h20, 1'b0, 32'h10};
        vt[2] = '{1'b1, 2'b00, 1'b1, 1'b0, 32'h24, 1'b0, 32'h10};
        vt[3] = '{1'b1, 2'b01, 1'b1, 1'b1, 32'h28, 1'b0, 32'h10};
        vt[4] = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h2C, 1'b1, 32'h2C};
        vt[5] = '{1'b1, 2'b10, 1'b0, 1'b1, 32'h30, 1'b0, 32'h2C};
        vt[6] = '{1'b1, 2'b11, 1'b1, 1'b1, 32'h34, 1'b1, 32'h34};

        PRESETn    = 1'b0;
        hready_ext = 1'b1;
        HWDATA     = 32'h0;
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) slv_mem[i] = 32'h0;
        @(negedge PCLK);
        @(negedge PCLK);
        #2;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Accept decode and PADDR hold, one address phase per vector from IDLE.
        for (int i = 0; i < 7; i++) begin
            bus(vt[i].sel, vt[i].tr, vt[i].wr, vt[i].addr);
            hready_ext = vt[i].rdy;
            HWDATA     = 32'h5000_0000 | vt[i].addr;
            tick();
            bus(1'b0, 2'b00, 1'b0, 32'h0);
            hready_ext = 1'b1;
            #2;
            chk($sformatf("vec%0d_psel", i), PSEL, vt[i].acc);
            chk($sformatf("vec%0d_paddr", i), PADDR, vt[i].exp_paddr);
            if (vt[i].acc) chk($sformatf("vec%0d_pwrite", i), PWRITE, vt[i].wr);
            n = 0;
            while (PSEL && n < 10) begin
                tick();
                #2;
                n++;
            end
            chk($sformatf("vec%0d_done", i), PSEL, 0);
        end

        // 1: single write, zero-wait peripheral
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b1, 32'h0);
        HWDATA = 32'hA5A5_0001;
        #2;
        chk("t1_idle_hreadyout", HREADYOUT, 1);
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        #2;
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_penable", PENABLE, 0);
        chk("t1_setup_hreadyout", HREADYOUT, 0);
        chk("t1_setup_pwdata", PWDATA, 32'hA5A5_0001);
        chk("t1_setup_pwrite", PWRITE, 1);
        tick();
        #2;
        chk("t1_access_psel_penable", {PSEL, PENABLE}, 2'b11);
        chk("t1_access_hreadyout", HREADYOUT, 1);
        chk("t1_access_hresp", HRESP, 0);
        tick();
        #2;
        chk("t1_end_psel_penable", {PSEL, PENABLE}, 2'b00);
        chk("t1_mem", slv_mem[0], 32'hA5A5_0001);

        // 2: single read
        slv_mem[0] = 32'h1234_5678;
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b0, 32'h0);
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        #2;
        chk("t2_setup_hreadyout", HREADYOUT, 0);
        chk("t2_setup_hrdata", HRDATA, 0);
        tick();
        #2;
        chk("t2_access_hreadyout", HREADYOUT, 1);
        chk("t2_access_hrdata", HRDATA, 32'h1234_5678);
        tick();
        #2;
        chk("t2_idle_hrdata", HRDATA, 0);

        // 3: back-to-back writes
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b1, 32'h0);
        HWDATA = 32'h1111_1111;
        n_psel = 0;
        tick();
        bus(1'b1, 2'b10, 1'b1, 32'h4);
        #2;
        n_psel += int'(PSEL);
        tick();
        #2;
        n_psel += int'(PSEL);
        chk("t3_acc1_hreadyout", HREADYOUT, 1);
        chk("t3_acc1_paddr", PADDR, 32'h0);
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        HWDATA = 32'h2222_2222;
        #2;
        n_psel += int'(PSEL);
        chk("t3_setup2_penable", PENABLE, 0);
        chk("t3_setup2_paddr", PADDR, 32'h4);
        tick();
        #2;
        n_psel += int'(PSEL);
        chk("t3_acc2_hreadyout", HREADYOUT, 1);
        tick();
        #2;
        n_psel += int'(PSEL);
        chk("t3_psel_cycles", n_psel, 4);
        chk("t3_mem0", slv_mem[0], 32'h1111_1111);
        chk("t3_mem1", slv_mem[1], 32'h2222_2222);

        // 4: PREADY low three cycles, below the timeout
        slv_wait = 3;
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b1, 32'h8);
        HWDATA = 32'h4444_4444;
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        #2;
        n = 0;
        while (!HREADYOUT && n < 20) begin
            n++;
            tick();
            #2;
        end
        chk("t4_wait_cycles", n, 4);
        chk("t4_hresp", HRESP, 0);
        tick();
        #2;
        chk("t4_mem", slv_mem[2], 32'h4444_4444);

        // 5: stuck peripheral -> ERROR, then a normal read
        slv_wait = 1000;
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b1, 32'hC);
        HWDATA = 32'hDEAD_BEEF;
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        #2;
        n = 0;
        while (!HRESP && n < 20) begin
            n++;
            tick();
            #2;
        end
        chk("t5_cycles_before_err", n, 5);
        chk("t5_err1_hresp", HRESP, 1);
        chk("t5_err1_hreadyout", HREADYOUT, 0);
        chk("t5_err1_psel_penable", {PSEL, PENABLE}, 2'b00);
        slv_wait = 0;
        tick();
        bus(1'b1, 2'b10, 1'b0, 32'h0);
        #2;
        chk("t5_err2_hresp", HRESP, 1);
        chk("t5_err2_hreadyout", HREADYOUT, 1);
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        #2;
        chk("t5_rd_setup_psel", PSEL, 1);
        chk("t5_rd_setup_hresp", HRESP, 0);
        tick();
        #2;
        chk("t5_rd_hreadyout", HREADYOUT, 1);
        chk("t5_rd_hrdata", HRDATA, 32'h1111_1111);
        chk("t5_rd_hresp", HRESP, 0);
        chk("t5_no_write", slv_mem[3], 32'h0);

        // 6: reset asserted during ACCESS
        slv_wait = 1000;
        @(negedge PCLK);
        bus(1'b1, 2'b10, 1'b1, 32'h40);
        HWDATA = 32'h6666_6666;
        tick();
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        tick();
        #2;
        chk("t6_access", {PSEL, PENABLE}, 2'b11);
        #1 PRESETn = 1'b0;
        #1;
        chk("t6_rst_psel_penable", {PSEL, PENABLE}, 2'b00);
        chk("t6_rst_hreadyout", HREADYOUT, 1);
        chk("t6_rst_hresp", HRESP, 0);
        @(negedge PCLK);
        PRESETn  = 1'b1;
        slv_wait = 0;
        tick();
        #2;
        chk("t6_after_psel", PSEL, 0);
        chk("t6_no_write", slv_mem[16], 32'h0);

        // Randomized traffic against a transaction-level model.
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            slv_mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < NR; i++) begin
            xq[i].addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            xq[i].wr    = 1'($urandom_range(0, 1));
            xq[i].seq   = 1'($urandom_range(0, 1));
            xq[i].wdata = $urandom;
            xq[i].w     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 2))
                                                      : int'($urandom_range(0, TO - 1));
            xq[i].gap   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end
        ap       = 0;
        dp       = -1;
        dp_cyc   = 0;
        gap_left = xq[0].gap;
        cyc      = 0;
        @(negedge PCLK);
        while ((ap < NR || dp >= 0) && cyc < 20000) begin
            presenting = (ap < NR) && (gap_left == 0);
            if (presenting) bus(1'b1, xq[ap].seq ? 2'b11 : 2'b10, xq[ap].wr, xq[ap].addr);
            else bus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     {24'h0, 6'($urandom_range(0, 63)), 2'b00});
            HWDATA = (dp >= 0) ? xq[dp].wdata : $urandom;
            if (dp >= 0) slv_wait = xq[dp].w;
            #2;
            if (dp >= 0) begin
                dp_cyc++;
                exp_err = (xq[dp].w >= TO);
                chk("rnd_hresp", HRESP, 32'(exp_err && dp_cyc >= TO + 2));
                if (HREADYOUT) begin
                    chk("rnd_len", dp_cyc, exp_err ? TO + 3 : xq[dp].w + 2);
                    idx = int'(xq[dp].addr[7:2]);
                    if (exp_err) begin
                        chk("rnd_err_psel", PSEL, 0);
                        chk("rnd_err_hrdata", HRDATA, 0);
                    end else begin
                        chk("rnd_paddr", PADDR, xq[dp].addr);
                        chk("rnd_pwrite", PWRITE, xq[dp].wr);
                        chk("rnd_access", {PSEL, PENABLE}, 2'b11);
                        if (xq[dp].wr) begin
                            chk("rnd_pwdata", PWDATA, xq[dp].wdata);
                            ref_mem[idx] = xq[dp].wdata;
                        end else begin
                            chk("rnd_hrdata", HRDATA, ref_mem[idx]);
                        end
                    end
                    dp = -1;
                end else begin
                    chk("rnd_wait_hrdata", HRDATA, 0);
                    if (dp_cyc > 2 * TO + 10) begin
                        chk("rnd_dataphase_bound", HREADYOUT, 1);
                        break;
                    end
                end
            end else begin
                chk("rnd_idle_psel", PSEL, 0);
                chk("rnd_idle_hreadyout", HREADYOUT, 1);
            end
            nxt = -1;
            if (presenting && HREADY) begin
                nxt = ap;
                ap++;
                if (ap < NR) gap_left = xq[ap].gap;
            end else if (!presenting && ap < NR) begin
                gap_left--;
            end
            tick();
            if (nxt >= 0) begin
                dp     = nxt;
                dp_cyc = 0;
            end
            cyc++;
        end
        chk("rnd_all_done", 32'(ap == NR && dp < 0), 1);
        bus(1'b0, 2'b00, 1'b0, 32'h0);
        tick();
        tick();
        mm = 0;
        for (int i = 0; i < 64; i++) if (slv_mem[i] !== ref_mem[i]) mm++;
        chk("mem_final_mismatches", mm, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
